// File: rtl/stack_alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_alu_sequencer_if
// Description : Instruction and response valid/ready bundle for the stack ALU
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_alu_sequencer_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;
  logic         out_err;

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_err
  );

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_err
  );
endinterface
`default_nettype wire

// File: rtl/stack_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stack_alu_sequencer
// Description : Issues stack instructions to the ALU one at a time and mirrors
//               its depth. Macro STACK_SEQ_GUARD_EN enables the depth guard.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_alu_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  stack_alu_sequencer_if.slave   bus,
  output logic [2:0]             alu_opcode,
  output logic [N-1:0]           alu_data,
  input  logic [N-1:0]           alu_result,
  input  logic                   alu_overflow,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int DW = $clog2(DEPTH) + 1;

  localparam logic [2:0]    c_op_add    = 3'b100;
  localparam logic [2:0]    c_op_mul    = 3'b101;
  localparam logic [2:0]    c_op_push   = 3'b110;
  localparam logic [2:0]    c_op_pop    = 3'b111;
  localparam logic [DW-1:0] c_depth_max = DW'(DEPTH);
  localparam logic [DW-1:0] c_depth_one = DW'(1);
  localparam logic [DW-1:0] c_depth_two = DW'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_op;
  logic [N-1:0]  r_data;
  logic          r_err;
  logic [N-1:0]  r_out_data;
  logic          r_out_ovf;
  logic [DW-1:0] r_depth;
  logic          w_guard_err;
  logic          w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

  always_comb begin
    w_guard_err = 1'b0;
`ifdef STACK_SEQ_GUARD_EN
    case (bus.in_op)
      c_op_push:          w_guard_err = (r_depth == c_depth_max);
      c_op_pop:           w_guard_err = (r_depth == '0);
      c_op_add, c_op_mul: w_guard_err = (r_depth < c_depth_two);
      default:            w_guard_err = 1'b1;
    endcase
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = w_guard_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_state_nxt = (r_op == c_op_push) ? S_IDLE : S_CAPT;
      S_CAPT:  w_state_nxt = S_RESP;
      S_RESP:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op       <= 3'b000;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_depth    <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.in_op;
        r_data <= bus.in_data;
        r_err <= w_guard_err;
        if (w_guard_err) begin
          r_out_data <= '0;
          r_out_ovf  <= 1'b0;
        end
      end
      // Saturation only matters when the guard is compiled out.
      if (r_state == S_ISSUE) begin
        if (r_op == c_op_push) begin
          if (r_depth != c_depth_max) r_depth <= r_depth + c_depth_one;
        end else if (r_op[2]) begin
          if (r_depth != '0) r_depth <= r_depth - c_depth_one;
        end
      end
      if (r_state == S_CAPT) begin
        r_out_data <= alu_result;
        r_out_ovf  <= (r_op == c_op_pop) ? 1'b0 : alu_overflow;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_RESP);
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_err   = r_err;
  assign alu_opcode    = (r_state == S_ISSUE) ? r_op : 3'b000;
  assign alu_data      = (r_state == S_ISSUE) ? r_data : '0;
  assign depth         = r_depth;

endmodule
`default_nettype wire

// File: doc/stack_alu_sequencer.md
# stack_alu_sequencer

Issue controller for the stack-based ALU. Accepts a stream of stack instructions over a valid/ready handshake, drives the ALU opcode/data inputs one operation at a time, and mirrors the stack depth so it can refuse underflowing or overflowing operations. Returns the results of ADD/MUL/POP and error reports on a valid/ready response port. Sits between the instruction source and the ALU instance.

## Interface
- N, 8, data width; must match the ALU's N
- DEPTH, 32, ALU stack capacity in entries
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept
- in_op  in  3  100 ADD, 101 MUL, 110 PUSH, 111 POP; 0xx illegal
- in_data  in  N  PUSH operand, ignored otherwise
- out_valid  out  1  response available
- out_ready  in  1  consumer takes response
- out_data  out  N  signed result; 0 on error
- out_ovf  out  1  ALU overflow flag for ADD/MUL; 0 for POP/error
- out_err  out  1  instruction rejected, not issued
- alu_opcode  out  3  to ALU; 000 (NOP) except in ISSUE
- alu_data  out  N  to ALU input_data
- alu_result  in  N  ALU output_data
- alu_overflow  in  1  ALU overflow
- depth  out  $clog2(DEPTH)+1  mirrored stack occupancy, 0..DEPTH

## Operation
- States: IDLE, ISSUE, CAPT, RESP.
- IDLE: in_ready=1. On in_valid, latch op/data and run guard:
  - PUSH with depth==DEPTH: error.
  - ADD/MUL with depth<2: error.
  - POP with depth==0: error.
  - op 0xx: error.
  - Error -> RESP with out_err=1, out_data=0, out_ovf=0; depth unchanged; ALU untouched.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle): alu_opcode=latched op, alu_data=latched data. Depth update at end of cycle: PUSH +1; ADD, MUL, POP -1. PUSH -> IDLE (no response); others -> CAPT.
- CAPT (1 cycle): alu_opcode=000; register alu_result and alu_overflow (overflow forced 0 for POP) into out_data/out_ovf -> RESP.
- RESP: out_valid=1, outputs held stable until out_ready; on out_valid&out_ready -> IDLE.
- in_ready=0 in ISSUE, CAPT and RESP; one instruction in flight.
- ADD/MUL consume the top two entries and leave the result on top; the arithmetic is done in the ALU, and the sequencer only does depth bookkeeping.

## Timing
- Reset (rst=0, async): state IDLE, depth 0, in_ready 1 once rst=1, out_valid 0, out_data 0, out_ovf 0, out_err 0, alu_opcode 000, alu_data 0.
- Accept at edge E; ISSUE is the cycle after E; ALU executes at the end of ISSUE; CAPT samples at the end of the next cycle; out_valid is asserted 3 cycles after E.
- PUSH throughput: 1 instruction per 2 cycles. ADD/MUL/POP: 4 cycles minimum, plus backpressure.
- Error response: out_valid is asserted 1 cycle after E.
- Reset mid-operation: the in-flight instruction and any pending response are dropped and depth returns to 0. The ALU must share the same reset so that the depth mirror stays coherent.
- out_ready is ignored outside RESP.

## Configuration
- STACK_SEQ_GUARD_EN
  - Defined: the depth guard and out_err behave as specified above.
  - Undefined: every op is issued to the ALU, including 0xx, which is issued as-is. out_err is tied to 0. depth saturates at 0 and DEPTH. Response latency is unchanged.

## Test plan
- Reset, then PUSH 10, PUSH -20, ADD -> response out_data=-10, out_ovf=0, out_err=0, depth=1; out_valid exactly 3 cycles after ADD accept.
- Continuing: PUSH 30, MUL -> out_data=-44 (-300 wrapped), out_ovf=1, depth=1; then POP -> out_data=-44, depth=0.
- POP on empty and ADD with depth=1 -> out_err=1, out_data=0, alu_opcode stays 000, depth unchanged (guard build).
- 32 PUSHes of 1..32 -> depth=32; 33rd PUSH -> out_err=1, depth stays 32; POP -> out_data=32, depth=31.
- Backpressure: hold out_ready=0 for 5 cycles in RESP -> out_valid/out_data stable, in_ready=0, no new accept; release -> IDLE next cycle.
- Assert rst low during CAPT of a MUL -> all outputs at reset values immediately, depth=0, no response after rst is released.
